// File: rtl/contador_m_updown_pkg.sv
// Shared defaults and direction constants for the contador_m counter family.
package contador_m_updown_pkg;

  localparam int DEF_WIDTH  = 6;
  localparam int DEF_MODULO = 64;
  localparam int DEF_HALF   = 32;

  // Values of the up input.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/contador_m_term.sv
// Combinational detector for the counter: terminal value for the current
// direction, half-count compare point and clamp of the parallel-load value.
module contador_m_term
  import contador_m_updown_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int MODULO = DEF_MODULO,
  parameter int HALF   = DEF_HALF
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic             at_term,
  output logic             at_half,
  output logic [WIDTH-1:0] d_clamped
);

  // Highest legal count; when MODULO == 2^WIDTH this is all ones, so the
  // natural WIDTH-bit roll-over already gives the modulo behaviour.
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] HALF_Q = WIDTH'(HALF - 1);

  // Illegal parameter sets stop elaboration instead of building a bad counter.
  if (MODULO < 2 || MODULO > (1 << WIDTH) || HALF < 1 || HALF >= MODULO) begin : g_bad_params
    $error("contador_m_term: illegal parameters (need 2<=MODULO<=2^WIDTH, 1<=HALF<MODULO)");
  end

  // Terminal is MODULO-1 when counting up and 0 when counting down.
  assign at_term   = (up == DIR_UP) ? (q == MAX_Q) : (q == '0);
  assign at_half   = (q == HALF_Q);
  assign d_clamped = (d > MAX_Q) ? MAX_Q : d;

endmodule

// File: rtl/contador_m_updown.sv
// Parametrised up/down modulo counter with synchronous clear and load,
// optional saturation at the terminal value, cascadable rco/half_rco flags
// and a registered one-cycle wrap pulse.
module contador_m_updown
  import contador_m_updown_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULO   = DEF_MODULO,
  parameter int HALF     = DEF_HALF,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             clr,
  input  logic             sclr,
  input  logic             ld,
  input  logic             ent,
  input  logic             enp,
  input  logic             up,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             half_rco,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULO - 1);

  logic             at_term;
  logic             at_half;
  logic [WIDTH-1:0] d_clamped;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

  contador_m_term #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO),
    .HALF   (HALF)
  ) u_term (
    .q         (Q),
    .d         (D),
    .up        (up),
    .at_term   (at_term),
    .at_half   (at_half),
    .d_clamped (d_clamped)
  );

  // Flags are gated by ent only, so rco can feed ent of the next slice.
  assign rco      = ent && at_term;
  assign half_rco = ent && at_half;

  // Next-state mux: clear beats load beats count beats hold.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    q_next    = Q;
    wrap_next = 1'b0;
    if (!sclr) begin
      q_next = '0;
    end else if (!ld) begin
      q_next = d_clamped;
    end else if (ent && enp) begin
      wrap_next = at_term;
      if (!at_term)
        q_next = (up == DIR_UP) ? Q + 1'b1 : Q - 1'b1;
      else if (SATURATE == 0)
        q_next = (up == DIR_UP) ? '0 : MAX_Q;
    end
  end

  // Count register and wrap flop, cleared asynchronously by clr.
  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      Q    <= '0;
      wrap <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      Q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule
